// File: rtl/pvr_pkg.sv
// Shared types for the PVR parameter-cache controller: default geometry,
// port-issue state and the read-return pipe entry.
package pvr_pkg;

    localparam int PCACHE_ENTRIES = 4096;
    localparam int PCACHE_TAG_W   = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_WR = 2'd1,
        ISSUE_RD = 2'd2
    } pcache_state_t;

    typedef struct packed {
        logic                    valid;
        logic [PCACHE_TAG_W-1:0] tag;
        logic                    oob;
    } pcache_rd_pipe_t;

endpackage

// File: rtl/pcache_ctrl.sv
// Arbitrates param_buffer's single port between fetcher writes and rasterizer reads; allocates write tags.
// Latency: grant combinational in N, pcache_tag/pcache_write in N+1, rd_valid in N+2; one grant per cycle.
// Backpressure: requests held until acked; reads win unless PCACHE_FAIR_ARB_EN forces a write; full stalls writes.
module pcache_ctrl
    import pvr_pkg::*;
#(
    parameter int ENTRIES      = PCACHE_ENTRIES,
    parameter int TAG_W        = PCACHE_TAG_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             wr_req,
    output logic             wr_ack,
    output logic [TAG_W-1:0] wr_tag,
    input  logic             rd_req,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_ack,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag_out,
    output logic             rd_oob,
    output logic [TAG_W-1:0] pcache_tag,
    output logic             pcache_write,
    output logic             full,
    output logic [TAG_W:0]   fill_count
);

    if (ENTRIES != (1 << TAG_W) || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("pcache_ctrl: ENTRIES must equal 2**TAG_W and STARVE_LIMIT must be >= 1");
    end

    pcache_state_t   state_q, state_d;
    pcache_rd_pipe_t pipe_s1_q, pipe_s2_q;
    logic [TAG_W:0]  fill_q;
    logic [TAG_W-1:0] tag_q;
    logic            rd_grant, wr_grant, wr_pend, force_wr, rd_oob_now;

    // alloc_ptr is the low bits of the fill count: both advance and clear together
    assign full       = (fill_q == (TAG_W+1)'(ENTRIES));
    assign wr_pend    = wr_req && !full;
    assign rd_oob_now = ({1'b0, rd_tag} >= fill_q);

`ifdef PCACHE_FAIR_ARB_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q;

    assign force_wr = wr_pend && (starve_q >= STARVE_W'(STARVE_LIMIT));

    always_ff @(posedge clock) begin
        if (reset || frame_start || wr_grant || !wr_req) begin
            starve_q <= '0;
        end else if (rd_grant && wr_pend) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    always_comb begin
        state_d  = IDLE;
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (!reset && !frame_start) begin
            if (rd_req && !force_wr) begin
                rd_grant = 1'b1;
                state_d  = ISSUE_RD;
            end else if (wr_pend) begin
                wr_grant = 1'b1;
                state_d  = ISSUE_WR;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q     <= '0;
            fill_q    <= '0;
            pipe_s1_q <= '0;
            pipe_s2_q <= '0;
        end else begin
            if (wr_grant) begin
                tag_q <= fill_q[TAG_W-1:0];
            end else if (rd_grant) begin
                tag_q <= rd_tag;
            end

            if (frame_start) begin
                fill_q <= '0;
            end else if (wr_grant) begin
                fill_q <= fill_q + 1'b1;
            end

            pipe_s1_q.valid <= rd_grant;
            if (rd_grant) begin
                pipe_s1_q.tag <= PCACHE_TAG_W'(rd_tag);
                pipe_s1_q.oob <= rd_oob_now;
            end
            pipe_s2_q <= pipe_s1_q;
        end
    end

    assign rd_ack       = rd_grant;
    assign wr_ack       = wr_grant;
    assign wr_tag       = fill_q[TAG_W-1:0];
    assign pcache_tag   = tag_q;
    assign pcache_write = (state_q == ISSUE_WR);
    assign fill_count   = fill_q;
    assign rd_valid     = pipe_s2_q.valid;
    assign rd_tag_out   = TAG_W'(pipe_s2_q.tag);
    assign rd_oob       = pipe_s2_q.oob;

endmodule

// File: tb/tb_pcache_ctrl.sv
// Bench for pcache_ctrl: transaction-level model checked every cycle plus directed
// scenarios with literal expectations; follows PCACHE_FAIR_ARB_EN when defined.
module tb_pcache_ctrl;

    localparam int ENTRIES      = 4096;
    localparam int TAG_W        = 12;
    localparam int STARVE_LIMIT = 4;
`ifdef PCACHE_FAIR_ARB_EN
    localparam int EXP_CONT_RD = 8;
    localparam int EXP_CONT_WR = 2;
`else
    localparam int EXP_CONT_RD = 10;
    localparam int EXP_CONT_WR = 0;
`endif

    logic             clock;
    logic             reset, frame_start, wr_req, rd_req;
    logic [TAG_W-1:0] rd_tag;
    logic             wr_ack, rd_ack, rd_valid, rd_oob, pcache_write, full;
    logic [TAG_W-1:0] wr_tag, rd_tag_out, pcache_tag;
    logic [TAG_W:0]   fill_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    pcache_ctrl #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_tag(wr_tag),
        .rd_req(rd_req), .rd_tag(rd_tag), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_tag_out(rd_tag_out), .rd_oob(rd_oob),
        .pcache_tag(pcache_tag), .pcache_write(pcache_write),
        .full(full), .fill_count(fill_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Stand-in for param_buffer: each write stores the next sequence word 0x0100, 0x0101, ...
    logic [15:0] pb_mem [ENTRIES];
    logic [15:0] pb_data;
    int          wseq = 0;
    always @(posedge clock) begin
        if (pcache_write) begin
            pb_mem[pcache_tag] <= 16'h0100 + wseq[15:0];
            wseq <= wseq + 1;
        end
        pb_data <= pb_mem[pcache_tag];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: pending reads are due two cycles after their grant
    typedef struct {
        int due;
        int tag;
        bit oob;
    } rd_exp_t;

    rd_exp_t pend[$];
    int      m_fill   = 0;
    int      m_pc_tag = 0;
    bit      m_pc_wr  = 1'b0;
    int      m_starve = 0;
    bit      g_rd, g_wr, force_w, m_full;

    always @(negedge clock) begin
        m_full = (m_fill == ENTRIES);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            chk("m_rd_valid", rd_valid, 1);
            chk("m_rd_tag_out", rd_tag_out, pend[0].tag);
            chk("m_rd_oob", rd_oob, pend[0].oob);
            void'(pend.pop_front());
        end else begin
            chk("m_rd_valid_idle", rd_valid, 0);
        end
        chk("m_pcache_write", pcache_write, m_pc_wr);
        chk("m_pcache_tag", pcache_tag, m_pc_tag);
        chk("m_fill_count", fill_count, m_fill);
        chk("m_full", full, m_full);

        force_w = 1'b0;
`ifdef PCACHE_FAIR_ARB_EN
        force_w = wr_req && !m_full && (m_starve >= STARVE_LIMIT);
`endif
        g_rd = !reset && !frame_start && rd_req && !force_w;
        g_wr = !reset && !frame_start && !g_rd && wr_req && !m_full;
        chk("m_rd_ack", rd_ack, g_rd);
        chk("m_wr_ack", wr_ack, g_wr);
        if (g_wr) chk("m_wr_tag", wr_tag, m_fill);

        if (reset) begin
            pend.delete();
            m_fill = 0; m_pc_tag = 0; m_pc_wr = 1'b0; m_starve = 0;
        end else begin
            if (frame_start || g_wr || !wr_req) m_starve = 0;
            else if (g_rd && !m_full) m_starve++;
            m_pc_wr = g_wr;
            if (g_rd) begin
                pend.push_back('{cyc + 2, int'(rd_tag), int'(rd_tag) >= m_fill});
                m_pc_tag = int'(rd_tag);
            end
            if (g_wr) begin
                m_pc_tag = m_fill;
                m_fill++;
            end
            if (frame_start) m_fill = 0;
        end
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded its time budget (%0d tests, %0d failed)", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic step_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    initial begin
        int               n_rd, n_wr, n;
        logic [TAG_W-1:0] oob_tags [3];
        bit               oob_exp  [3];
        oob_tags[0] = 12'd4; oob_tags[1] = 12'd5; oob_tags[2] = 12'd7;
        oob_exp[0]  = 1'b0;  oob_exp[1]  = 1'b1;  oob_exp[2]  = 1'b1;

        reset = 1'b1; frame_start = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_tag = '0;
        repeat (2) step_cyc();
        wr_req = 1'b1;
        smp(); chk("ack_in_reset", wr_ack, 0);
        step_cyc(); reset = 1'b0; wr_req = 1'b0;
        smp();
        chk("rst_pcache_tag", pcache_tag, 0);
        chk("rst_pcache_write", pcache_write, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_fill_count", fill_count, 0);
        chk("rst_full", full, 0);

        // Write path: three back-to-back grants
        step_cyc(); wr_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("wr_ack", wr_ack, 1);
            chk("wr_tag", wr_tag, k);
            if (k > 0) begin
                chk("wr_pc_write", pcache_write, 1);
                chk("wr_pc_tag", pcache_tag, k - 1);
            end
            step_cyc();
        end
        wr_req = 1'b0;
        smp();
        chk("wr_pc_write_last", pcache_write, 1);
        chk("wr_pc_tag_last", pcache_tag, 2);
        chk("wr_fill_3", fill_count, 3);

        // Read latency
        step_cyc(); rd_req = 1'b1; rd_tag = 12'd1;
        smp(); chk("rd_ack", rd_ack, 1);
        step_cyc(); rd_req = 1'b0;
        smp(); chk("rd_pc_tag", pcache_tag, 1); chk("rd_pc_write", pcache_write, 0);
        step_cyc();
        smp();
        chk("rd_valid", rd_valid, 1);
        chk("rd_tag_out", rd_tag_out, 1);
        chk("rd_oob_inrange", rd_oob, 0);
        chk("rd_data", pb_data, 16'h0101);

        // Read-after-write: read tag 3 in the cycle after its write grant
        step_cyc(); wr_req = 1'b1;
        smp(); chk("raw_wr_tag", wr_tag, 3);
        step_cyc(); wr_req = 1'b0; rd_req = 1'b1; rd_tag = 12'd3;
        smp(); chk("raw_rd_ack", rd_ack, 1); chk("raw_pc_write", pcache_write, 1);
        step_cyc(); rd_req = 1'b0;
        smp();
        step_cyc();
        smp(); chk("raw_valid", rd_valid, 1); chk("raw_data", pb_data, 16'h0103);

        // Contention: both requesters held for 10 cycles
        step_cyc(); wr_req = 1'b1; rd_req = 1'b1; rd_tag = 12'd0;
        n_rd = 0; n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
`ifdef PCACHE_FAIR_ARB_EN
            chk("fair_rd_slot", rd_ack, (i % 5) != 4);
            chk("fair_wr_slot", wr_ack, (i % 5) == 4);
`endif
            n_rd += int'(rd_ack);
            n_wr += int'(wr_ack);
            step_cyc();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        chk("cont_rd_grants", n_rd, EXP_CONT_RD);
        chk("cont_wr_grants", n_wr, EXP_CONT_WR);

        // Out-of-bounds reads around a fill count of 5
        frame_start = 1'b1;
        smp();
        step_cyc(); frame_start = 1'b0; wr_req = 1'b1;
        repeat (5) begin smp(); step_cyc(); end
        wr_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_req = (i < 3);
            if (i < 3) rd_tag = oob_tags[i];
            smp();
            if (i == 0) chk("oob_fill_5", fill_count, 5);
            if (i < 3) chk("oob_rd_ack", rd_ack, 1);
            if (i >= 2) begin
                chk("oob_valid", rd_valid, 1);
                chk("oob_tag_out", rd_tag_out, oob_tags[i-2]);
                chk("oob_flag", rd_oob, oob_exp[i-2]);
            end
            step_cyc();
        end
        rd_req = 1'b0;

        // Full: fill a whole frame, then reads still complete while writes stall
        frame_start = 1'b1; wr_req = 1'b1;
        smp(); chk("fs_no_grant", wr_ack, 0);
        step_cyc(); frame_start = 1'b0;
        n = 0;
        for (int i = 0; i < 5000 && n < ENTRIES; i++) begin
            smp();
            n += int'(wr_ack);
            step_cyc();
        end
        rd_req = 1'b1; rd_tag = 12'd9;
        smp();
        chk("full_grants", n, ENTRIES);
        chk("full_flag", full, 1);
        chk("full_fill", fill_count, ENTRIES);
        chk("full_no_wr_ack", wr_ack, 0);
        chk("full_rd_ack", rd_ack, 1);
        step_cyc(); rd_req = 1'b0;
        smp(); chk("full_still_no_wr", wr_ack, 0);
        step_cyc();
        smp(); chk("full_rd_valid", rd_valid, 1); chk("full_rd_tag", rd_tag_out, 9); chk("full_rd_oob", rd_oob, 0);
        step_cyc(); frame_start = 1'b1;
        smp(); chk("full_fs_no_ack", wr_ack, 0);
        step_cyc(); frame_start = 1'b0;
        smp();
        chk("refill_ack", wr_ack, 1);
        chk("refill_tag0", wr_tag, 0);
        chk("refill_not_full", full, 0);
        step_cyc(); wr_req = 1'b0;

        // Reset while a read is in flight
        rd_req = 1'b1; rd_tag = 12'd2;
        smp(); chk("rstrd_ack", rd_ack, 1);
        step_cyc(); rd_req = 1'b0; reset = 1'b1;
        smp();
        step_cyc(); reset = 1'b0;
        smp();
        chk("rstrd_no_valid", rd_valid, 0);
        chk("rstrd_pc_tag", pcache_tag, 0);
        chk("rstrd_pc_write", pcache_write, 0);
        chk("rstrd_fill", fill_count, 0);
        chk("rstrd_full", full, 0);
        chk("rstrd_tag_out", rd_tag_out, 0);
        chk("rstrd_oob", rd_oob, 0);

        repeat (3) step_cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pcache_ctrl.md
# pcache_ctrl

Sequencer/arbiter for the PVR primitive parameter cache (`param_buffer`). Shares the cache's single address/write-enable port between one writer (the primitive fetcher, which stores ISP/TSP/TCW words and three vertices) and one reader (the ISP/TSP rasterizer front-end, which reads primitives back by tag). It also allocates write tags sequentially and tracks fill level per tile/frame. The controller drives only `pcache_tag`/`pcache_write`; write data flows directly from the fetcher to `param_buffer`.

## Interface
Parameters:
- `ENTRIES`, 4096: cache depth; must be a power of two.
- `TAG_W`, 12: tag width, equal to log2(`ENTRIES`).
- `STARVE_LIMIT`, 4: maximum consecutive read grants while a write is pending (used only with `PCACHE_FAIR_ARB_EN`).

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  pulse; clears the allocation pointer and fill count.
- `wr_req`  in  1  fetcher requests one primitive write; held until `wr_ack`.
- `wr_ack`  out  1  combinational grant, same cycle as `wr_req`.
- `wr_tag`  out  TAG_W  tag allocated to the granted write; valid with `wr_ack`.
- `rd_req`  in  1  reader requests a primitive; held until `rd_ack`.
- `rd_tag`  in  TAG_W  tag to read; stable while `rd_req` is high.
- `rd_ack`  out  1  combinational grant.
- `rd_valid`  out  1  pulse: `param_buffer` outputs hold the requested primitive.
- `rd_tag_out`  out  TAG_W  tag that corresponds to `rd_valid`.
- `rd_oob`  out  1  pulse with `rd_valid` when the read tag was at or above the fill count.
- `pcache_tag`  out  TAG_W  registered address to `param_buffer.prim_tag`.
- `pcache_write`  out  1  registered write enable to `param_buffer`.
- `full`  out  1  fill count equals `ENTRIES`.
- `fill_count`  out  TAG_W+1  number of primitives written since the last `frame_start` or reset.

## Operation
- States: `IDLE` (no issue this cycle), `ISSUE_WR`, `ISSUE_RD`. This is the registered state of the port for the next cycle.
- Grant per cycle N, at most one grant:
  - If `frame_start`: no grant.
  - Else if `rd_req`, and the fairness rule does not force a write: `rd_ack`.
  - Else if `wr_req` and not `full`: `wr_ack`.
- Write grant: `wr_tag` = `alloc_ptr`. At the end of N, `pcache_tag`<=`alloc_ptr`, `pcache_write`<=1, `alloc_ptr`++, `fill_count`++.
- Read grant: `pcache_tag`<=`rd_tag`, `pcache_write`<=0. Tag and oob flag enter a 2-stage valid pipe.
- No grant: `pcache_write`<=0 and `pcache_tag` holds its value.
- `full`: `wr_req` is never acked. Reads continue. The writer stalls until `frame_start`.
- `alloc_ptr` never wraps within a frame, because `full` blocks at `ENTRIES`.
- `frame_start` zeroes `alloc_ptr` and `fill_count` at the end of the cycle. An in-flight read still produces `rd_valid`. A write issued in the previous cycle still completes.
- Read of a tag at or above `fill_count`: the read is performed and `rd_oob`=1 with `rd_valid`. The data is stale but defined.
- Read-after-write: a read of tag T granted in the cycle after T's write grant returns the new data.

## Timing
- Request and grant in cycle N.
- `pcache_tag`/`pcache_write` are driven in N+1; the memory write commits at the end of N+1.
- Read data appears on `param_buffer` outputs in N+2. `rd_valid`/`rd_tag_out`/`rd_oob` are asserted in N+2.
- Throughput: one grant per cycle, sustained back-to-back for either requester.
- Reset values: `pcache_tag`=0, `pcache_write`=0, `rd_valid`=0, `rd_tag_out`=0, `rd_oob`=0, `fill_count`=0, `full`=0, `alloc_ptr`=0, state `IDLE`, read pipe cleared.
- Reset mid-operation: in-flight reads are discarded and no `rd_valid` follows.
- `wr_ack`/`rd_ack` are 0 while `reset` is high.

## Configuration
- `PCACHE_FAIR_ARB_EN` defined:
  - A starvation counter counts consecutive read grants while `wr_req && !full`.
  - When it reaches `STARVE_LIMIT`, the next cycle grants the write even if `rd_req` is high.
  - The counter clears on any write grant, on any cycle without pending `wr_req`, and on `frame_start`.
- Not defined: strict read priority. The counter is absent and `STARVE_LIMIT` is ignored.

## Structure
- Shared package `pvr_pkg`: `ENTRIES`/`TAG_W` defaults, a `pcache_state_t` enum (`IDLE`, `ISSUE_WR`, `ISSUE_RD`), and a `pcache_rd_pipe_t` struct {valid, tag, oob}.
- Single module; no sub-module. The starvation counter is inline logic under the macro.

## Test plan
- Write path: reset, then `wr_req` held 3 cycles → `wr_ack` in each cycle, `wr_tag`=0,1,2. `pcache_write`=1 with `pcache_tag`=0,1,2 in the following cycles; `fill_count`=3.
- Read latency: `rd_req` with `rd_tag`=1 in cycle N → `pcache_tag`=1, `pcache_write`=0 at N+1. `rd_valid`=1, `rd_tag_out`=1, `rd_oob`=0 at N+2, with data equal to what was written.
- Contention: `rd_req` and `wr_req` both held for 10 cycles.
  - Without the macro: 10 read grants, 0 write grants.
  - With the macro and `STARVE_LIMIT`=4: grant pattern R,R,R,R,W repeating.
- Full: 4096 write grants → `full`=1, `fill_count`=4096. A further `wr_req` is never acked while a read still completes. After `frame_start`, the next `wr_tag`=0.
- Out-of-bounds read: `fill_count`=5, read of tag 7 → `rd_valid`=1, `rd_oob`=1.
- Reset mid-read: read granted at N, `reset` at N+1 → no `rd_valid` at N+2, and all outputs return to their reset values.
